// File: rtl/amo_req_initiator.sv
`default_nettype none
// ============================================================================
// Module      : amo_req_initiator
// Description : Core-side initiator for a TCDM bank port with atomic support.
//               It accepts one 32-bit request at a time and places it in the
//               correct lane of a DataWidth-wide bank word. It drives the
//               req/gnt handshake and captures read data or the AMO old value.
//               It returns a 32-bit response. Malformed AMOs are rejected
//               without any bank access, and a grant wait that runs too long
//               is aborted with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module amo_req_initiator #(
  parameter int AddrWidth    = 32,
  parameter int AddrMemWidth = 32,
  parameter int DataWidth    = 64,
  parameter int MaxGntWait   = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic [3:0]               req_amo_i,
  input  logic                     req_we_i,
  input  logic [31:0]              req_wdata_i,
  input  logic [3:0]               req_be_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     bank_req_o,
  input  logic                     bank_gnt_i,
  output logic [AddrMemWidth-1:0]  bank_add_o,
  output logic [3:0]               bank_amo_o,
  output logic                     bank_wen_o,
  output logic [DataWidth-1:0]     bank_wdata_o,
  output logic [DataWidth/8-1:0]   bank_be_o,
  input  logic [DataWidth-1:0]     bank_rdata_i,
  output logic                     busy_o
);

  localparam int BE_WIDTH  = DataWidth / 8;
  localparam int OFF_WIDTH = $clog2(BE_WIDTH);
  localparam int CNT_WIDTH = (MaxGntWait > 0) ? $clog2(MaxGntWait + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]              state;
  logic [CNT_WIDTH-1:0]    wait_cnt;
  logic                    upper;
  logic                    upper_next;
  logic [AddrWidth-1:0]    addr_shifted;
  logic [AddrMemWidth-1:0] add_next;
  logic [DataWidth-1:0]    wdata_next;
  logic [BE_WIDTH-1:0]     be_next;
  logic [31:0]             rdata_word;
  logic                    is_amo;
  logic                    req_err;
  logic                    timeout_hit;

  assign addr_shifted = req_addr_i >> OFF_WIDTH;

  // The word address either drops surplus upper address bits or gets
  // zero-extended, depending on which side is wider.
  if (AddrMemWidth <= AddrWidth) begin : g_add_trunc
    assign add_next = addr_shifted[AddrMemWidth-1:0];
  end else begin : g_add_ext
    assign add_next = {{(AddrMemWidth - AddrWidth){1'b0}}, addr_shifted};
  end

  // Lane mapping. A 64-bit bank holds two 32-bit lanes, selected by address
  // bit 2. Write data is replicated so that the byte enables alone pick the
  // lane.
  if (DataWidth == 64) begin : g_dw64
    assign upper_next = req_addr_i[2];
    assign wdata_next = {req_wdata_i, req_wdata_i};
    assign be_next    = upper_next ? {req_be_i, 4'h0} : {4'h0, req_be_i};
    assign rdata_word = upper ? bank_rdata_i[63:32] : bank_rdata_i[31:0];
  end else if (DataWidth == 32) begin : g_dw32
    assign upper_next = 1'b0;
    assign wdata_next = req_wdata_i;
    assign be_next    = req_be_i;
    assign rdata_word = bank_rdata_i;
  end else begin : g_dw_bad
    $fatal(1, "amo_req_initiator: DataWidth must be 32 or 64");
  end

  // AMOs must be word-aligned full-word operations. CAS (0xA) and undefined
  // codes cannot be served on this port.
  assign is_amo  = (req_amo_i != 4'h0);
  assign req_err = is_amo && ((req_addr_i[1:0] != 2'b00) ||
                              (req_be_i != 4'hF) ||
                              (req_amo_i >= 4'hA));

  assign timeout_hit = (MaxGntWait != 0) &&
                       ((wait_cnt + CNT_WIDTH'(1)) == CNT_WIDTH'(MaxGntWait));

  assign req_ready_o = (state == IDLE);
  assign bank_req_o  = (state == REQ);
  assign rsp_valid_o = (state == RSP);
  assign busy_o      = (state != IDLE);

  // Transaction sequencer: it latches the fields at accept, runs the
  // grant/data phases and holds the response until it is taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      upper        <= 1'b0;
      bank_add_o   <= '0;
      bank_amo_o   <= 4'h0;
      bank_wen_o   <= 1'b0;
      bank_wdata_o <= '0;
      bank_be_o    <= '0;
      rsp_rdata_o  <= 32'h0;
      rsp_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            bank_add_o   <= add_next;
            bank_amo_o   <= req_amo_i;
            bank_wen_o   <= req_we_i & ~is_amo;
            bank_wdata_o <= wdata_next;
            bank_be_o    <= be_next;
            upper        <= upper_next;
            rsp_rdata_o  <= 32'h0;
            wait_cnt     <= '0;
            rsp_err_o    <= req_err;
            state        <= req_err ? RSP : REQ;
          end
        end
        REQ: begin
          if (bank_gnt_i) begin
            // Stores have no read data, so they skip the capture cycle.
            state <= bank_wen_o ? RSP : DATA;
          end else if (timeout_hit) begin
            rsp_err_o <= 1'b1;
            state     <= RSP;
          end else if (MaxGntWait != 0) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
          end
        end
        DATA: begin
          rsp_rdata_o <= rdata_word;
          state       <= RSP;
        end
        RSP: begin
          if (rsp_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/amo_req_initiator.md
Name: amo_req_initiator

Overview:
- Core-side initiator for the TCDM bank atomic/load/store protocol; the requesting end of the bank port that an AMO-capable SRAM shim serves.
- Accepts one 32-bit request at a time over valid/ready and maps it onto a DataWidth-wide bank word (lane select, byte enables, data replication).
- Drives req/gnt, captures read/old data the cycle after grant, and returns a 32-bit response over valid/ready.
- Adds request checking and a grant-wait timeout.

Parameters:
- AddrWidth, 32, byte address width on the core side.
- AddrMemWidth, 32, bank word address width.
- DataWidth, 64, bank data width; only 32 or 64 legal; elaboration fatal otherwise.
- MaxGntWait, 255, cycles in REQ without grant before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted
- req_addr_i  in  AddrWidth  byte address
- req_amo_i  in  4  op code: 0 none, 1 swap, 2 add, 3 and, 4 or, 5 xor, 6 max, 7 maxu, 8 min, 9 minu, A cas
- req_we_i  in  1  1 store, 0 load; ignored when req_amo_i != 0
- req_wdata_i  in  32  store data / AMO operand
- req_be_i  in  4  byte enables
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_rdata_o  out  32  load data / AMO old value; 0 for stores and errors
- rsp_err_o  out  1  request rejected or timed out
- bank_req_o  out  1  bank request
- bank_gnt_i  in  1  bank grant
- bank_add_o  out  AddrMemWidth  bank word address
- bank_amo_o  out  4  op code to bank
- bank_wen_o  out  1  1 store, 0 load/AMO
- bank_wdata_o  out  DataWidth  write data
- bank_be_o  out  DataWidth/8  byte enables
- bank_rdata_i  in  DataWidth  read data
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE.
  - All registered fields cleared: bank_req_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, bank_add_o/wdata/be/amo/wen=0, busy_o=0.
  - Reset mid-transaction drops the transaction silently, with no response.
- Field mapping:
  - bank_add_o = req_addr_i >> log2(DataWidth/8), truncated/zero-extended to AddrMemWidth.
  - upper = req_addr_i[2] if DataWidth=64, else 0.
  - bank_wdata_o = {req_wdata_i, req_wdata_i} for 64 (plain req_wdata_i for 32).
  - bank_be_o = upper ? {req_be_i, 4'h0} : {4'h0, req_be_i}.
  - bank_wen_o = req_we_i & (req_amo_i==0).
  - All fields are registered at accept.
- Error checks at accept (no bank access; go straight to RSP with err=1):
  - AMO with req_addr_i[1:0]!=0.
  - AMO with req_be_i!=4'hF.
  - AMO code >4'hA.
  - AMO code CAS (4'hA), which is unsupported on this port.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch the request.
  - Error -> RSP. Otherwise -> REQ, and clear the wait counter.
- REQ:
  - bank_req_o=1, fields held stable.
  - bank_gnt_i=1 -> bank_req_o deasserts next cycle. A non-AMO store goes to RSP (rdata 0, err 0); load/AMO goes to DATA.
  - No grant -> increment the wait counter. If MaxGntWait!=0 and the counter reaches MaxGntWait -> RSP with err=1, bank_req_o drops.
- DATA (one cycle):
  - Capture rsp_rdata_o = upper ? bank_rdata_i[63:32] : bank_rdata_i[31:0].
  - Go to RSP.
  - For AMOs this is the pre-op memory value.
- RSP:
  - rsp_valid_o=1; rdata/err held stable until rsp_ready_i.
  - On handshake -> IDLE. A new request can be accepted the cycle after.
- Latency (no stall): accept at T, bank_req_o at T+1, grant at T+1, rsp_valid_o at T+3 for load/AMO and T+2 for store.
- Single outstanding request; req_ready_o=0 in all states except IDLE.
- The bank is never requested in the cycle after an AMO grant (the bank is busy committing). This holds because a response always intervenes.

Test Plan:
- Load, 64-bit, addr 0x0000_000C, bank_rdata_i=0x1122_3344_5566_7788, immediate gnt -> bank_add_o=1, bank_be_o=0xF0, bank_wen_o=0; rsp_rdata_o=0x1122_3344 at T+3, err=0.
- AMO add, addr 0x10, wdata 5, be F, bank old lower word 7 -> bank_amo_o=2, bank_wen_o=0, bank_be_o=0x0F, bank_wdata_o=0x0000_0005_0000_0005; rsp_rdata_o=7.
- Store, addr 0x4, be 0x3, wdata 0xABCD -> bank_wen_o=1, bank_be_o=0x30; response at T+2 with rdata 0, err 0.
- Misaligned AMO swap at addr 0x2 -> no bank_req_o ever; rsp_err_o=1 at T+1.
- MaxGntWait=4, gnt held 0 -> bank_req_o high 4 cycles then low; rsp_err_o=1. Next request with gnt works normally.
- rsp_ready_i held 0 for 5 cycles, then reset asserted in RSP -> rsp_valid_o held with stable data; reset clears all outputs to 0 and returns to IDLE.
